// File: rtl/bcd_countdown_ctrl.sv
// ============================================================================
// Module      : bcd_countdown_ctrl
// Description : 2-digit BCD countdown sequencer (IDLE/RUN/PAUSE/DONE) with
//               anode-scanned sharing of one BCD-to-7-segment decoder.
//               Segments and DP are active-low; DP is held off (1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_7sd (
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg      // {A,B,C,D,E,F,G}, active-low
);
    always_comb begin
        o_seg = 7'b111_1111;
        case (i_bcd)
            4'd0: o_seg = 7'b000_0001;
            4'd1: o_seg = 7'b100_1111;
            4'd2: o_seg = 7'b001_0010;
            4'd3: o_seg = 7'b000_0110;
            4'd4: o_seg = 7'b100_1100;
            4'd5: o_seg = 7'b010_0100;
            4'd6: o_seg = 7'b010_0000;
            4'd7: o_seg = 7'b000_1111;
            4'd8: o_seg = 7'b000_0000;
            4'd9: o_seg = 7'b000_0100;
            default: o_seg = 7'b111_1111;
        endcase
    end
endmodule

module bcd_countdown_ctrl #(
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 100_000,
    parameter int STEP     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] count,
    output logic       running,
    output logic       done,
    output logic [1:0] an,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       E,
    output logic       F,
    output logic       G,
    output logic       DP
);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] c_scan_last = SCAN_W'(SCAN_DIV - 1);
    localparam logic [3:0]        c_step      = 4'(STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [7:0]          r_count;
    logic [TICK_W-1:0]   r_tick;
    logic                r_running;
    logic                r_done;
    logic [SCAN_W-1:0]   r_scan;
    logic                r_sel;
    logic [1:0]          r_an;

    logic [3:0] w_ld_tens, w_ld_ones;
    logic [3:0] w_ones, w_tens;
    logic       w_borrow, w_sat;
    logic [3:0] w_step_ones, w_step_tens;
    logic [7:0] w_step_cnt;
    logic [3:0] w_digit;
    logic [6:0] w_seg;

    assign w_ld_tens = (load_value[7:4] > 4'd9) ? 4'd9 : load_value[7:4];
    assign w_ld_ones = (load_value[3:0] > 4'd9) ? 4'd9 : load_value[3:0];

    // Mod-16 arithmetic is exact here: the borrowed ones result is always 0..9.
    assign w_ones      = r_count[3:0];
    assign w_tens      = r_count[7:4];
    assign w_borrow    = (w_ones < c_step);
    assign w_sat       = (w_tens == 4'd0) && w_borrow;
    assign w_step_ones = w_borrow ? (w_ones + 4'd10 - c_step) : (w_ones - c_step);
    assign w_step_tens = w_borrow ? (w_tens - 4'd1) : w_tens;
    assign w_step_cnt  = w_sat ? 8'h00 : {w_step_tens, w_step_ones};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= 8'h00;
            r_tick    <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else if (load) begin
            r_state   <= S_IDLE;
            r_count   <= {w_ld_tens, w_ld_ones};
            r_tick    <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_tick <= '0;
                        if (r_count == 8'h00) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        r_state   <= S_PAUSE;
                        r_running <= 1'b0;
                    end else if (r_tick == c_tick_last) begin
                        r_tick  <= '0;
                        r_count <= w_step_cnt;
                        if (w_step_cnt == 8'h00) begin
                            r_state   <= S_DONE;
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                S_PAUSE: begin
                    // tick_cnt is left untouched so the interrupted step resumes.
                    if (start) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    // Anode and select flip on the same edge so the decoder never shows a stale digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan <= '0;
            r_sel  <= 1'b0;
            r_an   <= 2'b10;
        end else if (r_scan == c_scan_last) begin
            r_scan <= '0;
            r_sel  <= ~r_sel;
            r_an   <= r_sel ? 2'b10 : 2'b01;
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

    assign w_digit = r_sel ? r_count[7:4] : r_count[3:0];

    bcd_to_7sd u_bcd_to_7sd (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    assign {A, B, C, D, E, F, G} = w_seg;
    assign DP      = 1'b1;
    assign count   = r_count;
    assign running = r_running;
    assign done    = r_done;
    assign an      = r_an;

endmodule

`default_nettype wire

// File: tb/tb_bcd_countdown_ctrl.sv
// ============================================================================
// Module      : tb_bcd_countdown_ctrl
// Description : Directed + random bench; STEP=1 and STEP=3 instances share
//               stimulus and are checked every cycle against a decimal model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_countdown_ctrl;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'h00;
    logic       start = 1'b0;
    logic       pause = 1'b0;

    logic [7:0] o_cnt [2];
    logic       o_run [2];
    logic       o_done[2];
    logic [1:0] o_an  [2];
    logic       sa[2], sb[2], sc[2], sd[2], se[2], sf[2], sg[2], sdp[2];

    int n_assert = 0;
    int n_fail   = 0;

    int m_val [2];
    int m_st  [2];
    int m_tick[2];
    int m_step[2];
    int m_scan = 0;

    string lit[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                       "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    always #5 clk = ~clk;

    bcd_countdown_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .STEP(1)) u_dut1 (
        .clk(clk), .rst(rst), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .count(o_cnt[0]), .running(o_run[0]),
        .done(o_done[0]), .an(o_an[0]), .A(sa[0]), .B(sb[0]), .C(sc[0]),
        .D(sd[0]), .E(se[0]), .F(sf[0]), .G(sg[0]), .DP(sdp[0])
    );

    bcd_countdown_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .STEP(3)) u_dut3 (
        .clk(clk), .rst(rst), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .count(o_cnt[1]), .running(o_run[1]),
        .done(o_done[1]), .an(o_an[1]), .A(sa[1]), .B(sb[1]), .C(sc[1]),
        .D(sd[1]), .E(se[1]), .F(sf[1]), .G(sg[1]), .DP(sdp[1])
    );

    function automatic logic [6:0] seg_exp(input int digit);
        logic [6:0] s;
        string      l;
        s = 7'h7F;
        l = lit[digit];
        for (int i = 0; i < l.len(); i++)
            s[6 - (int'(l.getc(i)) - 97)] = 1'b0;
        return s;
    endfunction

    function automatic int clamp_dec(input logic [7:0] v);
        int t, o;
        t = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        o = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return t * 10 + o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) m_scan = 0;
        else     m_scan++;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_val[k] = 0; m_st[k] = M_IDLE; m_tick[k] = 0;
            end else if (load) begin
                m_val[k] = clamp_dec(load_value); m_st[k] = M_IDLE; m_tick[k] = 0;
            end else if (pause && m_st[k] == M_RUN) begin
                m_st[k] = M_PAUSE;
            end else if (start && m_st[k] == M_IDLE) begin
                m_st[k]   = (m_val[k] == 0) ? M_DONE : M_RUN;
                m_tick[k] = 0;
            end else if (start && m_st[k] == M_PAUSE) begin
                m_st[k] = M_RUN;
            end else if (m_st[k] == M_RUN) begin
                m_tick[k]++;
                if (m_tick[k] == TICK_DIV) begin
                    m_tick[k] = 0;
                    m_val[k]  = (m_val[k] > m_step[k]) ? m_val[k] - m_step[k] : 0;
                    if (m_val[k] == 0) m_st[k] = M_DONE;
                end
            end
        end
    endtask

    task automatic check_all();
        int         sel, dig;
        logic [7:0] ecnt;
        sel = (m_scan / SCAN_DIV) % 2;
        for (int k = 0; k < 2; k++) begin
            ecnt = 8'((m_val[k] / 10) * 16 + (m_val[k] % 10));
            dig  = (sel == 1) ? m_val[k] / 10 : m_val[k] % 10;
            chk($sformatf("count[%0d]", k), 32'(o_cnt[k]), 32'(ecnt));
            chk($sformatf("running[%0d]", k), 32'(o_run[k]), 32'(m_st[k] == M_RUN));
            chk($sformatf("done[%0d]", k), 32'(o_done[k]), 32'(m_st[k] == M_DONE));
            chk($sformatf("an[%0d]", k), 32'(o_an[k]), (sel == 1) ? 32'h1 : 32'h2);
            chk($sformatf("seg[%0d]", k),
                32'({sa[k], sb[k], sc[k], sd[k], se[k], sf[k], sg[k], sdp[k]}),
                32'({seg_exp(dig), 1'b1}));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_value = v;
        cyc();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    initial begin
        m_step[0] = 1; m_step[1] = 3;
        for (int k = 0; k < 2; k++) begin
            m_val[k] = 0; m_st[k] = M_IDLE; m_tick[k] = 0;
        end

        rst = 1'b1; repeat (3) cyc(); rst = 1'b0;

        // Reset asserted in the middle of a run
        do_load(8'h12); do_start(); repeat (2) cyc();
        rst = 1'b1; repeat (3) cyc(); rst = 1'b0;
        chk("rst_count", 32'(o_cnt[0]), 32'h00);
        chk("rst_an", 32'(o_an[0]), 32'h2);
        chk("rst_done", 32'(o_done[0]), 32'h0);
        chk("rst_running", 32'(o_run[0]), 32'h0);

        // Plain countdown with a borrow across the tens digit
        do_load(8'h12); do_start();
        repeat (4) cyc(); chk("cd_11", 32'(o_cnt[0]), 32'h11);
        repeat (4) cyc(); chk("cd_10", 32'(o_cnt[0]), 32'h10);
        repeat (4) cyc(); chk("cd_09", 32'(o_cnt[0]), 32'h09);

        // Reaching zero, then start is ignored in DONE
        do_load(8'h02); do_start();
        repeat (4) cyc(); chk("z_01", 32'(o_cnt[0]), 32'h01);
        repeat (4) cyc();
        chk("z_00", 32'(o_cnt[0]), 32'h00);
        chk("z_done", 32'(o_done[0]), 32'h1);
        chk("z_run", 32'(o_run[0]), 32'h0);
        do_start(); repeat (3) cyc();
        chk("z_hold_done", 32'(o_done[0]), 32'h1);
        chk("z_hold_cnt", 32'(o_cnt[0]), 32'h00);

        // Pause freezes the tick phase
        do_load(8'h50); do_start(); repeat (2) cyc();
        pause = 1'b1; cyc(); pause = 1'b0;
        repeat (4) cyc();
        chk("p_frozen", 32'(o_cnt[0]), 32'h50);
        do_start();
        cyc(); chk("p_not_yet", 32'(o_cnt[0]), 32'h50);
        cyc(); chk("p_49", 32'(o_cnt[0]), 32'h49);

        // STEP=3 saturation, and clamping of non-BCD load digits
        do_load(8'h10); do_start();
        repeat (4) cyc(); chk("s3_07", 32'(o_cnt[1]), 32'h07);
        repeat (4) cyc(); chk("s3_04", 32'(o_cnt[1]), 32'h04);
        repeat (4) cyc(); chk("s3_01", 32'(o_cnt[1]), 32'h01);
        repeat (4) cyc();
        chk("s3_00", 32'(o_cnt[1]), 32'h00);
        chk("s3_done", 32'(o_done[1]), 32'h1);
        do_load(8'hAF);
        chk("clamp_99", 32'(o_cnt[0]), 32'h99);
        chk("clamp_99_s3", 32'(o_cnt[1]), 32'h99);

        // Scan display of a held value
        do_load(8'h47); repeat (6) cyc();

        // Start and pause together while running
        do_load(8'h30); do_start(); cyc();
        start = 1'b1; pause = 1'b1; cyc(); start = 1'b0; pause = 1'b0;
        chk("sp_pause", 32'(o_run[0]), 32'h0);
        repeat (5) cyc();

        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            rst        = (r < 2);
            load       = (r >= 2 && r < 6);
            load_value = 8'($urandom);
            start      = (r >= 6 && r < 22) || (r >= 30 && r < 33);
            pause      = (r >= 22 && r < 33);
            cyc();
            rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
